// File: rtl/hazard_scoreboard.sv
// Decode-stage issue controller: pending-write scoreboard, RAW/saturation stall, redirect flush
// and halt drain. Define SB_STATS_EN to add stall/flush event counters.
module hazard_scoreboard #(
    parameter int unsigned NREG         = 8,
    parameter int unsigned CNT_W        = 2,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_dec_valid,
    input  logic [$clog2(NREG)-1:0] i_dec_rs1,
    input  logic                    i_dec_use1,
    input  logic [$clog2(NREG)-1:0] i_dec_rs2,
    input  logic                    i_dec_use2,
    input  logic                    i_dec_wen,
    input  logic [$clog2(NREG)-1:0] i_dec_wreg,
    input  logic                    i_dec_halt,
    input  logic                    i_ex_redirect,
    input  logic                    i_wb_en,
    input  logic [$clog2(NREG)-1:0] i_wb_reg,
    output logic                    o_issue,
    output logic                    o_stall,
    output logic                    o_flush,
    output logic [NREG-1:0]         o_busy_mask,
    output logic                    o_halt_done,
`ifdef SB_STATS_EN
    output logic [15:0]             o_stall_count,
    output logic [15:0]             o_flush_count,
`endif
    output logic                    o_sb_err
);

    localparam int unsigned RW = $clog2(NREG);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {StRun, StFlush, StDrain, StHalted} state_e;

    // A single-cycle flush needs no FLUSH state: the redirect cycle itself is the flush.
    localparam state_e REDIR_ST = (FLUSH_CYCLES > 1) ? StFlush : StRun;

    state_e           r_state;
    logic [2:0]       r_flush_cnt;
    logic [CNT_W-1:0] r_cnt [NREG];
    logic [NREG-1:0]  r_busy_mask;
    logic             r_halt_done;
    logic             r_sb_err;

    logic             w_hazard;
    logic             w_redirect;
    logic             w_flush;
    logic             w_stall;
    logic             w_issue;
    logic             w_pending;
    logic             w_err_set;
    logic [NREG-1:0]  w_inc;
    logic [NREG-1:0]  w_dec;
    logic [NREG-1:0]  w_busy_d;
    logic [CNT_W-1:0] w_cnt_d [NREG];

    // No forwarding: a source stays blocked through its own writeback cycle.
    assign w_hazard = (i_dec_use1 && (r_cnt[i_dec_rs1] != '0))
                    | (i_dec_use2 && (r_cnt[i_dec_rs2] != '0))
                    | (i_dec_wen  && (r_cnt[i_dec_wreg] == CNT_MAX));

    assign w_redirect = i_ex_redirect && (r_state != StHalted);
    assign w_flush    = w_redirect || (r_state == StFlush);
    assign w_issue    = i_dec_valid && !w_hazard && !w_flush && (r_state == StRun);

    always_comb begin
        w_stall = 1'b0;
        unique case (r_state)
            StRun:    w_stall = i_dec_valid && w_hazard && !w_flush;
            StFlush:  w_stall = 1'b0;
            StDrain:  w_stall = !w_flush;  // an older redirect abandons the halt
            StHalted: w_stall = 1'b1;
            default:  w_stall = 1'b0;
        endcase
    end

    always_comb begin
        w_err_set = 1'b0;
        w_pending = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            w_inc[i]   = w_issue && i_dec_wen && (i_dec_wreg == RW'(i));
            w_dec[i]   = i_wb_en && (i_wb_reg == RW'(i));
            w_cnt_d[i] = r_cnt[i];
            if (w_inc[i] && !w_dec[i]) begin
                w_cnt_d[i] = r_cnt[i] + 1'b1;
            end else if (w_dec[i] && !w_inc[i]) begin
                if (r_cnt[i] == '0) w_err_set = 1'b1;
                else                w_cnt_d[i] = r_cnt[i] - 1'b1;
            end
            w_busy_d[i] = (w_cnt_d[i] != '0);
            w_pending   = w_pending | (r_cnt[i] != '0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StRun;
            r_flush_cnt <= '0;
            r_busy_mask <= '0;
            r_halt_done <= 1'b0;
            r_sb_err    <= 1'b0;
            for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) r_cnt[i] <= w_cnt_d[i];
            r_busy_mask <= w_busy_d;
            r_sb_err    <= r_sb_err | w_err_set;
            unique case (r_state)
                StRun: begin
                    if (w_redirect) begin
                        r_state     <= REDIR_ST;
                        r_flush_cnt <= FLUSH_INIT;
                    end else if (w_issue && i_dec_halt) begin
                        r_state <= StDrain;
                    end
                end
                StFlush: begin
                    if (w_redirect) begin
                        r_state     <= REDIR_ST;
                        r_flush_cnt <= FLUSH_INIT;
                    end else if (r_flush_cnt <= 3'd1) begin
                        r_state     <= StRun;
                        r_flush_cnt <= '0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 3'd1;
                    end
                end
                StDrain: begin
                    if (w_redirect) begin
                        r_state     <= REDIR_ST;
                        r_flush_cnt <= FLUSH_INIT;
                    end else if (!w_pending) begin
                        r_state     <= StHalted;
                        r_halt_done <= 1'b1;
                    end
                end
                StHalted: r_state <= StHalted;
                default:  r_state <= StRun;
            endcase
        end
    end

`ifdef SB_STATS_EN
    logic [15:0] r_stall_count;
    logic [15:0] r_flush_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_stall && (r_state == StRun) && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
            if (w_flush && (r_flush_count != 16'hFFFF)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign o_stall_count = r_stall_count;
    assign o_flush_count = r_flush_count;
`endif

    assign o_issue     = w_issue;
    assign o_stall     = w_stall;
    assign o_flush     = w_flush;
    assign o_busy_mask = r_busy_mask;
    assign o_halt_done = r_halt_done;
    assign o_sb_err    = r_sb_err;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard: RAW, saturation, redirect, halt, errors.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dec_valid, dec_use1, dec_use2, dec_wen, dec_halt;
    logic [2:0] dec_rs1, dec_rs2, dec_wreg, wb_reg;
    logic       ex_redirect, wb_en;
    logic       issue, stall, flush, halt_done, sb_err;
    logic [7:0] busy_mask;
`ifdef SB_STATS_EN
    logic [15:0] stall_count, flush_count;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_dec_valid  (dec_valid),
        .i_dec_rs1    (dec_rs1),
        .i_dec_use1   (dec_use1),
        .i_dec_rs2    (dec_rs2),
        .i_dec_use2   (dec_use2),
        .i_dec_wen    (dec_wen),
        .i_dec_wreg   (dec_wreg),
        .i_dec_halt   (dec_halt),
        .i_ex_redirect(ex_redirect),
        .i_wb_en      (wb_en),
        .i_wb_reg     (wb_reg),
        .o_issue      (issue),
        .o_stall      (stall),
        .o_flush      (flush),
        .o_busy_mask  (busy_mask),
        .o_halt_done  (halt_done),
`ifdef SB_STATS_EN
        .o_stall_count(stall_count),
        .o_flush_count(flush_count),
`endif
        .o_sb_err     (sb_err)
    );

    task automatic dec(input logic v, input logic u1, input logic [2:0] r1, input logic u2,
                       input logic [2:0] r2, input logic w, input logic [2:0] wr,
                       input logic h);
        dec_valid = v; dec_use1 = u1; dec_rs1 = r1; dec_use2 = u2; dec_rs2 = r2;
        dec_wen = w; dec_wreg = wr; dec_halt = h;
    endtask

    task automatic idle();
        dec(0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0);
        ex_redirect = 0; wb_en = 0; wb_reg = 3'd0;
    endtask

    task automatic wb(input logic en, input logic [2:0] r);
        wb_en = en; wb_reg = r;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        @(negedge clk); #1;
        n_total++; if (issue !== 1'b0) $display("FAIL rst_issue: got %b want 0", issue); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall); else n_pass++;
        n_total++; if (flush !== 1'b0) $display("FAIL rst_flush: got %b want 0", flush); else n_pass++;
        n_total++; if (busy_mask !== 8'h00) $display("FAIL rst_busy: got %h want 00", busy_mask); else n_pass++;
        n_total++; if (halt_done !== 1'b0) $display("FAIL rst_halt: got %b want 0", halt_done); else n_pass++;
        n_total++; if (sb_err !== 1'b0) $display("FAIL rst_err: got %b want 0", sb_err); else n_pass++;
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_raw();
        @(negedge clk); dec(1, 0, 3'd0, 0, 3'd0, 1, 3'd3, 0); #1;
        n_total++; if (issue !== 1'b1) $display("FAIL raw_wr_issue: got %b want 1", issue); else n_pass++;
        @(negedge clk); dec(1, 1, 3'd3, 0, 3'd0, 0, 3'd0, 0); #1;
        n_total++; if (stall !== 1'b1) $display("FAIL raw_stall: got %b want 1", stall); else n_pass++;
        n_total++; if (issue !== 1'b0) $display("FAIL raw_noissue: got %b want 0", issue); else n_pass++;
        n_total++; if (busy_mask !== 8'h08) $display("FAIL raw_busy: got %h want 08", busy_mask); else n_pass++;
        @(negedge clk); wb(1, 3'd3); #1;
        n_total++; if (stall !== 1'b1) $display("FAIL raw_wb_stall: got %b want 1", stall); else n_pass++;
        n_total++; if (issue !== 1'b0) $display("FAIL raw_wb_noissue: got %b want 0", issue); else n_pass++;
        @(negedge clk); wb(0, 3'd0); #1;
        n_total++; if (issue !== 1'b1) $display("FAIL raw_after_issue: got %b want 1", issue); else n_pass++;
        n_total++; if (busy_mask !== 8'h00) $display("FAIL raw_busy_clr: got %h want 00", busy_mask); else n_pass++;
        @(negedge clk); idle();
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); dec(1, 0, 3'd0, 0, 3'd0, 1, 3'd5, 0); #1;
            n_total++; if (issue !== 1'b1) $display("FAIL sat_issue%0d: got %b want 1", k, issue); else n_pass++;
        end
        @(negedge clk); #1;
        n_total++; if (stall !== 1'b1) $display("FAIL sat_stall: got %b want 1", stall); else n_pass++;
        n_total++; if (issue !== 1'b0) $display("FAIL sat_noissue: got %b want 0", issue); else n_pass++;
        n_total++; if (busy_mask !== 8'h20) $display("FAIL sat_busy: got %h want 20", busy_mask); else n_pass++;
        @(negedge clk); wb(1, 3'd5); #1;
        n_total++; if (stall !== 1'b1) $display("FAIL sat_wb_stall: got %b want 1", stall); else n_pass++;
        @(negedge clk); wb(0, 3'd0); #1;
        n_total++; if (issue !== 1'b1) $display("FAIL sat_4th_issue: got %b want 1", issue); else n_pass++;
        @(negedge clk); idle(); wb(1, 3'd5);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); wb(0, 3'd0); #1;
        n_total++; if (busy_mask !== 8'h00) $display("FAIL sat_busy_clr: got %h want 00", busy_mask); else n_pass++;
        n_total++; if (sb_err !== 1'b0) $display("FAIL sat_err: got %b want 0", sb_err); else n_pass++;
    endtask

    task automatic test_redirect();
        @(negedge clk); dec(1, 0, 3'd0, 0, 3'd0, 1, 3'd1, 0); ex_redirect = 1; #1;
        n_total++; if (flush !== 1'b1) $display("FAIL redir_flush0: got %b want 1", flush); else n_pass++;
        n_total++; if (issue !== 1'b0) $display("FAIL redir_issue0: got %b want 0", issue); else n_pass++;
        @(negedge clk); ex_redirect = 0; #1;
        n_total++; if (flush !== 1'b1) $display("FAIL redir_flush1: got %b want 1", flush); else n_pass++;
        n_total++; if (issue !== 1'b0) $display("FAIL redir_issue1: got %b want 0", issue); else n_pass++;
        @(negedge clk); dec(1, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0); #1;
        n_total++; if (flush !== 1'b0) $display("FAIL redir_flush2: got %b want 0", flush); else n_pass++;
        n_total++; if (issue !== 1'b1) $display("FAIL redir_issue2: got %b want 1", issue); else n_pass++;
        n_total++; if (busy_mask !== 8'h00) $display("FAIL redir_busy: got %h want 00", busy_mask); else n_pass++;
        @(negedge clk); idle();
    endtask

    task automatic test_redirect_stall();
        @(negedge clk); dec(1, 0, 3'd0, 0, 3'd0, 1, 3'd2, 0); #1;
        n_total++; if (issue !== 1'b1) $display("FAIL rs_wr_issue: got %b want 1", issue); else n_pass++;
        @(negedge clk); dec(1, 0, 3'd0, 1, 3'd2, 1, 3'd7, 0); #1;
        n_total++; if (stall !== 1'b1) $display("FAIL rs_stall: got %b want 1", stall); else n_pass++;
        @(negedge clk); ex_redirect = 1; #1;
        n_total++; if (flush !== 1'b1) $display("FAIL rs_flush: got %b want 1", flush); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL rs_nostall: got %b want 0", stall); else n_pass++;
        n_total++; if (issue !== 1'b0) $display("FAIL rs_noissue: got %b want 0", issue); else n_pass++;
        @(negedge clk); ex_redirect = 0; #1;
        n_total++; if (flush !== 1'b1) $display("FAIL rs_flush_hold: got %b want 1", flush); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL rs_flush_nostall: got %b want 0", stall); else n_pass++;
        @(negedge clk); idle(); #1;
        n_total++; if (flush !== 1'b0) $display("FAIL rs_flush_end: got %b want 0", flush); else n_pass++;
        n_total++; if (busy_mask !== 8'h04) $display("FAIL rs_busy: got %h want 04", busy_mask); else n_pass++;
        @(negedge clk); wb(1, 3'd2);
        @(negedge clk); wb(0, 3'd0); #1;
        n_total++; if (busy_mask !== 8'h00) $display("FAIL rs_busy_clr: got %h want 00", busy_mask); else n_pass++;
    endtask

    task automatic test_halt();
        @(negedge clk); dec(1, 0, 3'd0, 0, 3'd0, 1, 3'd1, 0);
        @(negedge clk); dec(1, 0, 3'd0, 0, 3'd0, 1, 3'd4, 0);
        @(negedge clk); dec(1, 0, 3'd0, 0, 3'd0, 0, 3'd0, 1); #1;
        n_total++; if (issue !== 1'b1) $display("FAIL halt_issue: got %b want 1", issue); else n_pass++;
        @(negedge clk); dec(1, 1, 3'd0, 0, 3'd0, 0, 3'd0, 0); #1;
        n_total++; if (stall !== 1'b1) $display("FAIL halt_stall: got %b want 1", stall); else n_pass++;
        n_total++; if (halt_done !== 1'b0) $display("FAIL halt_early: got %b want 0", halt_done); else n_pass++;
        n_total++; if (busy_mask !== 8'h12) $display("FAIL halt_busy: got %h want 12", busy_mask); else n_pass++;
        @(negedge clk); wb(1, 3'd1); #1;
        n_total++; if (stall !== 1'b1) $display("FAIL halt_drain_stall: got %b want 1", stall); else n_pass++;
        @(negedge clk); wb(1, 3'd4); #1;
        n_total++; if (halt_done !== 1'b0) $display("FAIL halt_wb4: got %b want 0", halt_done); else n_pass++;
        @(negedge clk); wb(0, 3'd0); #1;
        n_total++; if (halt_done !== 1'b0) $display("FAIL halt_zero: got %b want 0", halt_done); else n_pass++;
        n_total++; if (busy_mask !== 8'h00) $display("FAIL halt_busy_clr: got %h want 00", busy_mask); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (halt_done !== 1'b1) $display("FAIL halt_done: got %b want 1", halt_done); else n_pass++;
        n_total++; if (stall !== 1'b1) $display("FAIL halted_stall: got %b want 1", stall); else n_pass++;
        n_total++; if (issue !== 1'b0) $display("FAIL halted_issue: got %b want 0", issue); else n_pass++;
        idle(); rst_n = 0;
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_err_reset();
        @(negedge clk); wb(1, 3'd6);
        @(negedge clk); wb(0, 3'd0); #1;
        n_total++; if (sb_err !== 1'b1) $display("FAIL err_set: got %b want 1", sb_err); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (sb_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", sb_err); else n_pass++;
        @(negedge clk); dec(1, 0, 3'd0, 0, 3'd0, 1, 3'd0, 0); #1;
        n_total++; if (issue !== 1'b1) $display("FAIL err_wr_issue: got %b want 1", issue); else n_pass++;
        @(negedge clk); idle(); ex_redirect = 1;
        @(negedge clk); ex_redirect = 0; #1;
        n_total++; if (flush !== 1'b1) $display("FAIL err_in_flush: got %b want 1", flush); else n_pass++;
        n_total++; if (busy_mask !== 8'h01) $display("FAIL err_busy: got %h want 01", busy_mask); else n_pass++;
        #1 rst_n = 0;
        #1;
        n_total++; if (flush !== 1'b0) $display("FAIL arst_flush: got %b want 0", flush); else n_pass++;
        n_total++; if (sb_err !== 1'b0) $display("FAIL arst_err: got %b want 0", sb_err); else n_pass++;
        n_total++; if (busy_mask !== 8'h00) $display("FAIL arst_busy: got %h want 00", busy_mask); else n_pass++;
        @(negedge clk); rst_n = 1; #1;
        n_total++; if (flush !== 1'b0) $display("FAIL arst_post_flush: got %b want 0", flush); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL arst_post_stall: got %b want 0", stall); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_raw();
        test_saturation();
        test_redirect();
        test_redirect_stall();
        test_halt();
        test_err_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Issue controller for the decode stage of the 16-bit pipeline (fetch, decode, execute, mem, writeback).
- Tracks in-flight writes to the 8 architectural registers with a per-register pending counter.
- Stalls decode on RAW or counter-saturation hazards, squashes fetch/decode after a taken branch or jump resolves in execute, and sequences halt drain.
- Sits beside decode. Its stall and flush outputs gate the fetch/decode pipeline register and insert bubbles into execute.

Parameters:
- NREG, 8, number of architectural registers; register id width is clog2(NREG)=3.
- CNT_W, 2, width of each pending-write counter; maximum value is 2^CNT_W-1.
- FLUSH_CYCLES, 2, number of cycles flush is held after a redirect; legal range 1..7.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- dec_valid  in  1  decode holds a valid instruction.
- dec_rs1  in  3  first source register (RqRd).
- dec_use1  in  1  dec_rs1 is actually read.
- dec_rs2  in  3  second source register (Rs).
- dec_use2  in  1  dec_rs2 is actually read.
- dec_wen  in  1  instruction writes a register.
- dec_wreg  in  3  destination register.
- dec_halt  in  1  instruction is halt.
- ex_redirect  in  1  taken branch or jump resolved in execute this cycle.
- wb_en  in  1  writeback commits a register write.
- wb_reg  in  3  register being committed.
- issue  out  1  decode instruction accepted into execute this cycle.
- stall  out  1  hold PC and the fetch/decode register; bubble into execute.
- flush  out  1  squash fetch/decode contents.
- busy_mask  out  8  bit i is 1 when counter i is nonzero (registered).
- halt_done  out  1  halt has drained; pipeline idle.
- sb_err  out  1  sticky; set when wb_en arrives for a register whose counter is 0.

Behaviour:
- Reset (rst=0, async): all counters 0, state RUN, flush_cnt 0, issue/stall/flush 0, busy_mask 0, halt_done 0, sb_err 0.
- States:
  - RUN: normal issue.
  - FLUSH: flush_cnt>0, no issue.
  - DRAIN: halt issued, waiting for counters to empty.
  - HALTED: terminal until reset.
- hazard (combinational) = (dec_use1 & cnt[dec_rs1]!=0) | (dec_use2 & cnt[dec_rs2]!=0) | (dec_wen & cnt[dec_wreg]==max).
- flush = ex_redirect | (state==FLUSH); same-cycle response to ex_redirect.
- stall = dec_valid & hazard & ~flush in RUN; stall = 1 in DRAIN and HALTED.
- issue = dec_valid & ~hazard & ~flush & state==RUN.
- Counters:
  - issue & dec_wen increments cnt[dec_wreg].
  - wb_en decrements cnt[wb_reg].
  - Both on the same register in the same cycle: net unchanged.
  - Decrement at 0: counter stays 0 and sb_err is set.
  - Counters use no forwarding: a source is blocked until its writeback cycle. Same-cycle wb_en on a source register does NOT clear the hazard that cycle; issue occurs the following cycle.
- Transitions:
  - ex_redirect in any state except HALTED: go to FLUSH with flush_cnt=FLUSH_CYCLES-1. If FLUSH_CYCLES=1, remain in/return to RUN. Redirect takes priority over stall and halt issue; the decode instruction is not issued.
  - FLUSH: flush_cnt decrements each cycle; go to RUN when it reaches 0.
  - RUN: issue & dec_halt goes to DRAIN. A halt needs no sources, but a halt with dec_wen=1 is counted normally.
  - DRAIN: a redirect (older branch) goes to FLUSH and abandons the halt. When all counters are 0, go to HALTED.
  - HALTED: halt_done=1 and stall=1; counters still decrement on wb_en.
- Reset asserted mid-stall or mid-flush clears everything immediately; no partial state survives.
- busy_mask updates one cycle after the counter change.

Optional Feature:
- Macro: SB_STATS_EN.
- Defined: adds outputs stall_count[15:0] and flush_count[15:0].
  - stall_count increments on each cycle with stall=1 in RUN.
  - flush_count increments on each cycle with flush=1.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- RAW: issue write r3 (cnt[3]=1), next decode reads r3 with use1 -> stall=1, issue=0 until the wb_en r3 cycle; issue=1 the cycle after; busy_mask[3] returns to 0.
- Saturation: three issued writes to r5 with no writeback -> cnt=3; fourth write to r5 -> stall=1; one wb_en r5 -> fourth issues next cycle.
- Redirect: ex_redirect=1 for one cycle while dec_valid with no hazard -> flush=1 for 2 cycles (FLUSH_CYCLES=2), issue=0 both cycles, counters unchanged.
- Redirect during stall: stalled on r2 hazard, ex_redirect=1 -> flush=1, stall=0, state FLUSH; stalled instruction is never counted.
- Halt: r1 and r4 pending, halt issued -> stall=1, halt_done=0; wb r1 then wb r4 -> halt_done=1 the cycle after cnt reaches all-zero.
- Errors and reset: wb_en r6 with cnt[6]=0 -> sb_err=1 and stays set; rst=0 asynchronously mid-FLUSH -> flush=0, sb_err=0, busy_mask=0 before the next clock edge.
